// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage LSU: funct3 codes, FSM states, byte-lane helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_B, F3_BU: be_gen = 4'b0001 << off;
         F3_H, F3_HU: be_gen = 4'b0011 << off;
         default:     be_gen = 4'b1111;
      endcase
   endfunction

   // Store data is replicated across lanes so the byte enables alone pick the target.
   function automatic logic [31:0] store_rep(input logic [2:0] funct3, input logic [31:0] data);
      case (funct3)
         F3_B:    store_rep = {4{data[7:0]}};
         F3_H:    store_rep = {2{data[15:0]}};
         default: store_rep = data;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/half at the address offset and extends it.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_data = i_rdata;
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_data = {24'h0, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_data = {16'h0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-memory access per load/store, min 2 cycles (store) / 3 (load).
// Stalls the pipeline while the bus access is outstanding; illegal or timed-out accesses pulse ErrM.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int AW             = 32
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          MemReadM,
   input  logic          MemWriteM,
   input  logic [2:0]    Funct3M,
   input  logic [AW-1:0] AddrM,
   input  logic [AW-1:0] WriteDataM,
   output logic [AW-1:0] ReadDataM,
   output logic          StallM,
   output logic          ErrM,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [3:0]    dmem_be,
   output logic [AW-1:0] dmem_wdata,
   input  logic          dmem_ready,
   input  logic          dmem_rvalid,
   input  logic [AW-1:0] dmem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata;
   logic          r_req;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [3:0]    r_be;
   logic [31:0]   r_wdata;
   logic [2:0]    r_f3;
   logic [1:0]    r_off;
   logic          r_tmo;

   logic          w_one_op;
   logic          w_f3_ok;
   logic          w_aligned;
   logic          w_legal;
   logic          w_illegal;
   logic          w_expired;
   logic [31:0]   w_fmt;

   always_comb begin
      w_one_op = MemReadM ^ MemWriteM;
      if (MemReadM)
         w_f3_ok = Funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      else
         w_f3_ok = Funct3M inside {F3_B, F3_H, F3_W};
      case (Funct3M)
         F3_H, F3_HU: w_aligned = (AddrM[0] == 1'b0);
         F3_W:        w_aligned = (AddrM[1:0] == 2'b00);
         default:     w_aligned = 1'b1;
      endcase
      w_legal   = w_one_op && w_f3_ok && w_aligned;
      w_illegal = (r_state == IDLE) && (MemReadM || MemWriteM) && !w_legal;
      w_expired = (r_cnt == CNT_LAST);
   end

   load_align u_load_align (
      .i_rdata  (dmem_rdata),
      .i_funct3 (r_f3),
      .i_off    (r_off),
      .o_data   (w_fmt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_f3    <= '0;
         r_off   <= '0;
         r_tmo   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               r_tmo <= 1'b0;
               if (w_legal) begin
                  r_req   <= 1'b1;
                  r_we    <= MemWriteM;
                  r_addr  <= {AddrM[31:2], 2'b00};
                  r_be    <= be_gen(Funct3M, AddrM[1:0]);
                  r_wdata <= store_rep(Funct3M, WriteDataM);
                  r_f3    <= Funct3M;
                  r_off   <= AddrM[1:0];
                  r_rdata <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               // Saturate the count so a late accept leaves RESP with the remaining budget only.
               if (!w_expired)
                  r_cnt <= r_cnt + 1'b1;
               if (dmem_ready) begin
                  r_req   <= 1'b0;
                  r_state <= r_we ? DONE : RESP;
               end else if (w_expired) begin
                  r_req   <= 1'b0;
                  r_tmo   <= 1'b1;
                  r_state <= DONE;
               end
            end
            RESP: begin
               if (!w_expired)
                  r_cnt <= r_cnt + 1'b1;
               if (dmem_rvalid) begin
                  r_rdata <= w_fmt;
                  r_state <= DONE;
               end else if (w_expired) begin
                  r_tmo   <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_rdata <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ReadDataM  = r_rdata;
   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_be    = r_be;
   assign dmem_wdata = r_wdata;
   assign StallM     = ((r_state == IDLE) && w_legal) || (r_state == BUSY) || (r_state == RESP);
   assign ErrM       = w_illegal || ((r_state == DONE) && r_tmo);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inputs driven after negedge, outputs sampled 1ns later.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] AddrM, WriteDataM, ReadDataM;
   logic        StallM, ErrM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready, dmem_rvalid;

   int checks = 0;
   int errors = 0;
   int hs     = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (dmem_req && dmem_ready) hs++;

   mem_stage_lsu #(.TIMEOUT_CYCLES(8), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
      .StallM(StallM), .ErrM(ErrM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   task automatic clear_inputs();
      MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
      AddrM = 32'h0; WriteDataM = 32'h0;
   endtask

   // Drives one load with immediate accept and rvalid the following cycle; ends in the DONE cycle.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                          output logic [3:0] be, output logic [31:0] res);
      @(negedge clk); MemReadM = 1'b1; Funct3M = f3; AddrM = addr;
      @(negedge clk); dmem_ready = 1'b1; #1 be = dmem_be;
      @(negedge clk); dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
      @(negedge clk); dmem_rvalid = 1'b0; clear_inputs(); #1 res = ReadDataM;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear_inputs();
      dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0; #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, StallM, ErrM} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl got req=%b we=%b be=%b stall=%b err=%b exp all 0",
                            dmem_req, dmem_we, dmem_be, StallM, ErrM);
      end
      checks++;
      if ({dmem_addr, dmem_wdata, ReadDataM} !== 96'h0) begin
         errors++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0", dmem_addr, dmem_wdata, ReadDataM);
      end
   endtask

   task automatic test_lw();
      int stalls = 0;
      @(negedge clk); MemReadM = 1'b1; Funct3M = 3'b010; AddrM = 32'h100; #1;
      stalls += int'(StallM);
      checks++;
      if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_idle_req got %b exp 0", dmem_req); end
      @(negedge clk); #1; stalls += int'(StallM);
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
         errors++; $display("FAIL lw_bus got req=%b we=%b be=%b addr=%h exp 1 0 1111 00000100",
                            dmem_req, dmem_we, dmem_be, dmem_addr);
      end
      dmem_ready = 1'b1;
      @(negedge clk); #1; stalls += int'(StallM);
      checks++;
      if (dmem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr_stable got %h exp 00000100", dmem_addr); end
      @(negedge clk); dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
      stalls += int'(StallM);
      checks++;
      if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_resp_req got %b exp 0", dmem_req); end
      @(negedge clk); dmem_rvalid = 1'b0; dmem_rdata = 32'h0; clear_inputs(); #1;
      stalls += int'(StallM);
      checks++;
      if (ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", ReadDataM); end
      checks++;
      if (stalls != 4) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 4", stalls); end
      checks++;
      if (ErrM !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", ErrM); end
   endtask

   task automatic test_sb();
      int stalls = 0;
      @(negedge clk); MemWriteM = 1'b1; Funct3M = 3'b000; AddrM = 32'h203; WriteDataM = 32'h12345678; #1;
      stalls += int'(StallM);
      @(negedge clk); dmem_ready = 1'b1; #1; stalls += int'(StallM);
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, 4'b1000, 32'h78787878, 32'h200}) begin
         errors++; $display("FAIL sb_bus got req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 1000 78787878 00000200",
                            dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      end
      @(negedge clk); dmem_ready = 1'b0; clear_inputs(); #1; stalls += int'(StallM);
      checks++;
      if (stalls != 2) begin errors++; $display("FAIL sb_stall_cycles got %0d exp 2", stalls); end
      checks++;
      if (ErrM !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", ErrM); end
   endtask

   task automatic test_load_format();
      logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001};
      logic [31:0] ad [5]  = '{32'h302, 32'h302, 32'h302, 32'h302, 32'h300};
      logic [31:0] rd [5]  = '{32'h00F00000, 32'h00F00000, 32'h00F00000, 32'h00F00000, 32'h00008001};
      logic [31:0] ex [5]  = '{32'hFFFFFFF0, 32'h000000F0, 32'h000000F0, 32'h000000F0, 32'hFFFF8001};
      logic [3:0]  exb [5] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0011};
      logic [3:0]  be;
      logic [31:0] res;
      for (int i = 0; i < 5; i++) begin
         do_load(f3[i], ad[i], rd[i], be, res);
         checks++;
         if (res !== ex[i]) begin errors++; $display("FAIL fmt_%0d got %h exp %h", i, res, ex[i]); end
         checks++;
         if (be !== exb[i]) begin errors++; $display("FAIL fmt_be_%0d got %b exp %b", i, be, exb[i]); end
      end
   endtask

   task automatic test_illegal();
      logic        rdv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        wrv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3  [5] = '{3'b010, 3'b010, 3'b011, 3'b101, 3'b100};
      logic [31:0] ad  [5] = '{32'h101, 32'h100, 32'h100, 32'h301, 32'h100};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); MemReadM = rdv[i]; MemWriteM = wrv[i]; Funct3M = f3[i]; AddrM = ad[i]; #1;
         checks++;
         if ({ErrM, StallM, dmem_req, ReadDataM} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL illegal_%0d got err=%b stall=%b req=%b rdata=%h exp 1 0 0 0",
                               i, ErrM, StallM, dmem_req, ReadDataM);
         end
         @(negedge clk); clear_inputs(); #1;
         checks++;
         if ({ErrM, dmem_req} !== 2'b00) begin
            errors++; $display("FAIL illegal_after_%0d got err=%b req=%b exp 0 0", i, ErrM, dmem_req);
         end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      @(negedge clk); MemReadM = 1'b1; Funct3M = 3'b010; AddrM = 32'h500;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (dmem_req) n++;
         else break;
      end
      clear_inputs();
      checks++;
      if (n != 8) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 8", n); end
      checks++;
      if ({ErrM, StallM, ReadDataM} !== {1'b1, 1'b0, 32'h0}) begin
         errors++; $display("FAIL tmo_done got err=%b stall=%b rdata=%h exp 1 0 0", ErrM, StallM, ReadDataM);
      end
      @(negedge clk); #1;
      checks++;
      if ({ErrM, StallM, dmem_req} !== 3'b000) begin
         errors++; $display("FAIL tmo_after got err=%b stall=%b req=%b exp 0 0 0", ErrM, StallM, dmem_req);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); MemReadM = 1'b1; Funct3M = 3'b010; AddrM = 32'h600;
      @(negedge clk); dmem_ready = 1'b1;
      @(negedge clk); dmem_ready = 1'b0; dmem_rdata = 32'h55AA55AA; reset = 1'b1; #1;
      checks++;
      if (StallM !== 1'b1) begin errors++; $display("FAIL rst_in_resp_stall got %b exp 1", StallM); end
      @(negedge clk); reset = 1'b0; clear_inputs(); #1;
      checks++;
      if ({dmem_req, StallM, ErrM, ReadDataM} !== {3'b000, 32'h0}) begin
         errors++; $display("FAIL rst_mid got req=%b stall=%b err=%b rdata=%h exp 0 0 0 0",
                            dmem_req, StallM, ErrM, ReadDataM);
      end
      @(negedge clk); MemWriteM = 1'b1; Funct3M = 3'b010; AddrM = 32'h40; WriteDataM = 32'hCAFEF00D;
      @(negedge clk); dmem_ready = 1'b1; #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h40}) begin
         errors++; $display("FAIL rst_sw_bus got req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 1111 cafef00d 00000040",
                            dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      end
      @(negedge clk); dmem_ready = 1'b0; clear_inputs(); #1;
      checks++;
      if ({StallM, ErrM} !== 2'b00) begin
         errors++; $display("FAIL rst_sw_done got stall=%b err=%b exp 0 0", StallM, ErrM);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  be;
      logic [31:0] r0, r1;
      int          h0;
      h0 = hs;
      do_load(3'b010, 32'h10, 32'h11111111, be, r0);
      do_load(3'b100, 32'h11, 32'hAABBCCDD, be, r1);
      checks++;
      if (r0 !== 32'h11111111) begin errors++; $display("FAIL b2b_first got %h exp 11111111", r0); end
      checks++;
      if (r1 !== 32'h000000CC) begin errors++; $display("FAIL b2b_second got %h exp 000000cc", r1); end
      checks++;
      if (hs - h0 != 2) begin errors++; $display("FAIL b2b_handshakes got %0d exp 2", hs - h0); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sb();
      test_load_format();
      test_illegal();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
